// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic array skew feeder.
package systolic_pkg;

    localparam int N_DEF  = 4;
    localparam int DW_DEF = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Number of injection cycles: the last operand pair reaches PE(N-1,N-1)
    // after 2(N-1) skew cycles plus N accumulation steps.
    function automatic int RUN_LEN(input int n);
        return 3 * n - 2;
    endfunction

endpackage

// File: rtl/systolic_operand_bank.sv
// NxN operand register file: one synchronous write port, synchronous clear,
// every entry visible at once on a flat read bus (row-major, entry 0 in LSBs).
module systolic_operand_bank
    import systolic_pkg::*;
#(
    parameter int N  = N_DEF,
    parameter int DW = DW_DEF,
    localparam int IW = $clog2(N)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [IW-1:0]     wr_row,
    input  logic [IW-1:0]     wr_col,
    input  logic [DW-1:0]     wr_data,
    output logic [N*N*DW-1:0] rd
);

    logic [DW-1:0] mem [N][N];

    // Clear on reset; otherwise store one entry when the index is in range.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    mem[i][j] <= '0;
                end
            end
        end else if (wr_en && (int'(wr_row) < N) && (int'(wr_col) < N)) begin
            mem[wr_row][wr_col] <= wr_data;
        end
    end

    // Flatten the storage so the skew mux can reach every entry in parallel.
    always_comb begin
        rd = '0;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                rd[(i*N+j)*DW +: DW] = mem[i][j];
            end
        end
    end

endmodule

// File: rtl/systolic_skew_feeder.sv
// Feeds operand matrices A (rows -> side inputs) and B (columns -> ceiling
// inputs) into an NxN systolic MAC array with diagonal skew.
//
//   state | meaning
//   IDLE  | waiting for start, operand writes accepted
//   CLEAR | one cycle with pe_en low to zero the PE accumulators
//   RUN   | cnt steps 0..3N-3, skewed operands driven onto the buses
//   DONE  | buses zero, PEs hold A x B, writes and a new start accepted
module systolic_skew_feeder
    import systolic_pkg::*;
#(
    parameter int N  = N_DEF,
    parameter int DW = DW_DEF,
    localparam int IW = $clog2(N),
    localparam int CW = $clog2(3*N-1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wr_en,
    input  logic            wr_sel,
    input  logic [IW-1:0]   wr_row,
    input  logic [IW-1:0]   wr_col,
    input  logic [DW-1:0]   wr_data,
    input  logic            start,
    output logic [N*DW-1:0] side_bus,
    output logic [N*DW-1:0] ceil_bus,
    output logic            pe_en,
    output logic            busy,
    output logic            done,
    output logic            result_valid
);

    localparam logic [CW-1:0] CNT_LAST = CW'(RUN_LEN(N) - 1);

    state_t            state;
    state_t            state_nx;
    logic [CW-1:0]     cnt;
    logic              done_r;
    logic              wr_ok;
    logic [N*N*DW-1:0] rd_a;
    logic [N*N*DW-1:0] rd_b;

    // A start in the same cycle wins over a write, so the run sees the old banks.
    assign wr_ok = wr_en && !start && ((state == IDLE) || (state == DONE));

    systolic_operand_bank #(.N(N), .DW(DW)) u_bank_a (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_ok && !wr_sel),
        .wr_row  (wr_row),
        .wr_col  (wr_col),
        .wr_data (wr_data),
        .rd      (rd_a)
    );

    systolic_operand_bank #(.N(N), .DW(DW)) u_bank_b (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_ok && wr_sel),
        .wr_row  (wr_row),
        .wr_col  (wr_col),
        .wr_data (wr_data),
        .rd      (rd_b)
    );

    // Next-state decode.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = CLEAR;
            CLEAR:   state_nx = RUN;
            RUN:     if (cnt == CNT_LAST) state_nx = DONE;
            DONE:    if (start) state_nx = CLEAR;
            default: state_nx = IDLE;
        endcase
    end

    // State, run counter and the single-cycle done pulse on entry to DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            done_r <= 1'b0;
        end else begin
            state  <= state_nx;
            cnt    <= ((state == RUN) && (state_nx == RUN)) ? cnt + 1'b1 : '0;
            done_r <= (state == RUN) && (state_nx == DONE);
        end
    end

    // Skew mux: at step t, row a gets A[a][t-a] and column a gets B[t-a][a].
    always_comb begin
        side_bus = '0;
        ceil_bus = '0;
        if (state == RUN) begin
            for (int a = 0; a < N; a++) begin
                for (int b = 0; b < N; b++) begin
                    if (int'(cnt) == a + b) begin
                        side_bus[a*DW +: DW] = rd_a[(a*N+b)*DW +: DW];
                        ceil_bus[a*DW +: DW] = rd_b[(b*N+a)*DW +: DW];
                    end
                end
            end
        end
    end

    assign pe_en        = (state == RUN) || (state == DONE);
    assign busy         = (state == CLEAR) || (state == RUN);
    assign done         = done_r;
    assign result_valid = (state == DONE);

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Directed bench for systolic_skew_feeder (N=4, DW=8) driving a behavioural
// 4x4 array of MAC cells so end-to-end products can be checked.
module tb_systolic_skew_feeder;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic        wr_sel;
    logic [1:0]  wr_row;
    logic [1:0]  wr_col;
    logic [7:0]  wr_data;
    logic        start;
    logic [31:0] side_bus;
    logic [31:0] ceil_bus;
    logic        pe_en;
    logic        busy;
    logic        done;
    logic        result_valid;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] acc [4][4];
    logic [7:0] hr  [4][4];
    logic [7:0] vr  [4][4];

    // Hand-derived bus contents for A[i][k]=16i+k, B[k][j]=16k+j+128, cnt 0..9.
    logic [31:0] side_exp [10] = '{32'h00000000, 32'h00001001, 32'h00201102,
                                   32'h30211203, 32'h31221300, 32'h32230000,
                                   32'h33000000, 32'h00000000, 32'h00000000,
                                   32'h00000000};
    logic [31:0] ceil_exp [10] = '{32'h00000080, 32'h00008190, 32'h008291A0,
                                   32'h8392A1B0, 32'h93A2B100, 32'hA3B20000,
                                   32'hB3000000, 32'h00000000, 32'h00000000,
                                   32'h00000000};

    always #5 clk = ~clk;

    systolic_skew_feeder #(.N(4), .DW(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .wr_en        (wr_en),
        .wr_sel       (wr_sel),
        .wr_row       (wr_row),
        .wr_col       (wr_col),
        .wr_data      (wr_data),
        .start        (start),
        .side_bus     (side_bus),
        .ceil_bus     (ceil_bus),
        .pe_en        (pe_en),
        .busy         (busy),
        .done         (done),
        .result_valid (result_valid)
    );

    function automatic logic [7:0] hin(input int i, input int j);
        if (j == 0) return side_bus[i*8 +: 8];
        return hr[i][j-1];
    endfunction

    function automatic logic [7:0] vin(input int i, input int j);
        if (i == 0) return ceil_bus[j*8 +: 8];
        return vr[i-1][j];
    endfunction

    // Behavioural PE array: registered pass-through right/down, 8-bit MAC.
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                if (pe_en !== 1'b1) begin
                    acc[i][j] <= 8'h00;
                    hr[i][j]  <= 8'h00;
                    vr[i][j]  <= 8'h00;
                end else begin
                    acc[i][j] <= acc[i][j] + hin(i, j) * vin(i, j);
                    hr[i][j]  <= hin(i, j);
                    vr[i][j]  <= vin(i, j);
                end
            end
        end
    end

    function automatic logic [7:0] aval(input int mode, input int i, input int k);
        case (mode)
            0:       return 8'(16*i + k);
            1:       return (i == k) ? 8'h01 : 8'h00;
            2:       return 8'h02;
            3:       return 8'hFF;
            default: return 8'h01;
        endcase
    endfunction

    function automatic logic [7:0] bval(input int mode, input int k, input int j);
        case (mode)
            0:       return 8'(16*k + j + 128);
            1:       return 8'(k + j);
            2:       return 8'h03;
            3:       return 8'h02;
            default: return 8'h01;
        endcase
    endfunction

    // Hand-computed products: identity*B -> i+j; 2s*3s -> 24; FF*02 wraps to F8.
    function automatic logic [7:0] pe_exp(input int mode, input int i, input int j);
        case (mode)
            1:       return 8'(i + j);
            2:       return 8'd24;
            3:       return 8'hF8;
            4:       return 8'd4;
            default: return 8'h00;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic sel, input int r, input int c, input logic [7:0] d);
        wr_en   = 1'b1;
        wr_sel  = sel;
        wr_row  = 2'(r);
        wr_col  = 2'(c);
        wr_data = d;
        step();
        wr_en   = 1'b0;
    endtask

    task automatic load(input int mode);
        for (int i = 0; i < 4; i++) begin
            for (int k = 0; k < 4; k++) begin
                wr(1'b0, i, k, aval(mode, i, k));
                wr(1'b1, i, k, bval(mode, i, k));
            end
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Cycle 1 is CLEAR (first cycle after start is sampled); done due in cycle 12.
    task automatic wait_done(input string tag, input int exp_cyc, input int cyc0);
        int cyc;
        cyc = cyc0;
        while (done !== 1'b1 && cyc < 40) begin
            step();
            cyc++;
        end
        chk(tag, cyc, exp_cyc);
    endtask

    task automatic run(input string tag);
        pulse_start();
        wait_done({tag, "_latency"}, 12, 1);
    endtask

    task automatic chk_pe(input string tag, input int mode);
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                chk($sformatf("%s_pe%0d%0d", tag, i, j), acc[i][j], pe_exp(mode, i, j));
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ndone;
        rst = 1'b1; wr_en = 1'b0; wr_sel = 1'b0; wr_row = 2'd0; wr_col = 2'd0;
        wr_data = 8'h00; start = 1'b0;
        step();
        step();
        chk("rst_side", side_bus, 32'h0);
        chk("rst_ceil", ceil_bus, 32'h0);
        chk("rst_pe_en", pe_en, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_rv", result_valid, 1'b0);
        rst = 1'b0;

        // Empty banks after reset: nothing but zeros on the buses.
        pulse_start();
        chk("empty_clear_pe_en", pe_en, 1'b0);
        chk("empty_clear_busy", busy, 1'b1);
        for (int t = 0; t < 10; t++) begin
            step();
            chk($sformatf("empty_bus_t%0d", t), {side_bus | ceil_bus}, 32'h0);
        end
        step();
        chk("empty_done", done, 1'b1);
        chk_pe("empty", 0);

        // Skew timing with distinct operand values.
        load(0);
        pulse_start();
        chk("skew_clear_pe_en", pe_en, 1'b0);
        for (int t = 0; t < 10; t++) begin
            step();
            chk($sformatf("skew_side_t%0d", t), side_bus, side_exp[t]);
            chk($sformatf("skew_ceil_t%0d", t), ceil_bus, ceil_exp[t]);
            chk($sformatf("skew_done_t%0d", t), done, 1'b0);
            chk($sformatf("skew_busy_t%0d", t), {busy, pe_en}, 2'b11);
        end
        step();
        chk("skew_done_pulse", done, 1'b1);
        chk("skew_rv", result_valid, 1'b1);
        chk("skew_busy_done", busy, 1'b0);
        step();
        chk("skew_done_drop", done, 1'b0);
        chk("skew_rv_hold", result_valid, 1'b1);
        chk("skew_pe_en_hold", pe_en, 1'b1);
        chk("skew_bus_done", {side_bus | ceil_bus}, 32'h0);

        // End-to-end products.
        load(1);
        run("ident");
        chk_pe("ident", 1);
        load(2);
        run("twos");
        chk_pe("twos", 2);
        load(3);
        run("wrap");
        chk_pe("wrap", 3);

        // Writes and a second start during RUN are ignored.
        pulse_start();
        step();
        step();
        wr(1'b0, 0, 0, 8'h05);
        wr(1'b1, 1, 1, 8'h07);
        wr(1'b0, 3, 2, 8'h00);
        pulse_start();
        ndone = 0;
        for (int c = 0; c < 30; c++) begin
            if (done === 1'b1) ndone++;
            step();
        end
        chk("proto_single_done", ndone, 1);
        chk("proto_rv", result_valid, 1'b1);
        chk_pe("proto_run1", 3);
        run("proto_rerun");
        chk_pe("proto_run2", 3);

        // From DONE: fresh operands, CLEAR lasts exactly one cycle.
        load(4);
        pulse_start();
        chk("restart_clear_pe_en", pe_en, 1'b0);
        step();
        chk("restart_run_pe_en", pe_en, 1'b1);
        wait_done("restart_latency", 12, 2);
        chk_pe("restart", 4);

        // Start and write together: the write is dropped.
        wr_en = 1'b1; wr_sel = 1'b0; wr_row = 2'd0; wr_col = 2'd0; wr_data = 8'h09;
        start = 1'b1;
        step();
        wr_en = 1'b0; start = 1'b0;
        wait_done("collide_latency", 12, 1);
        chk("collide_pe00", acc[0][0], 8'd4);
        chk("collide_pe01", acc[0][1], 8'd4);

        // Reset in the middle of a run.
        pulse_start();
        step();
        step();
        step();
        rst = 1'b1;
        step();
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_pe_en", pe_en, 1'b0);
        chk("midrst_bus", {side_bus | ceil_bus}, 32'h0);
        chk("midrst_rv", result_valid, 1'b0);
        chk("midrst_done", done, 1'b0);
        step();
        rst = 1'b0;
        pulse_start();
        for (int t = 0; t < 10; t++) begin
            step();
            chk($sformatf("midrst_bank_t%0d", t), {side_bus | ceil_bus}, 32'h0);
        end
        wait_done("midrst_latency", 12, 11);
        chk_pe("midrst", 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
